// File: rtl/phase_seq_pkg.sv
// Shared types and defaults for the phase-driven fetch/execute sequencer.
// Holds the sequencer state encoding and the default debounce length.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        HALT       = 2'd0,
        RUN        = 2'd1,
        STEP_FETCH = 2'd2,
        STEP_EXEC  = 2'd3
    } state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 1000;

endpackage

// File: rtl/debounce.sv
// Button debouncer: 2-flop synchronizer, then a level filter that only
// accepts a new level after it has been stable for CYCLES clocks.
module debounce
    import phase_seq_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            // any sample matching the accepted level restarts the count
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(CYCLES - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/phase_sequencer.sv
// Turns two divider phases into fetch/execute strobes, gated by a
// run/halt/single-step controller with debounced front-panel buttons.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COUNT_W         = 32
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               phase_a,
    input  logic               phase_b,
    input  logic               run_btn,
    input  logic               step_btn,
    input  logic               halt_req,
    output logic               fetch_en,
    output logic               exec_en,
    output logic               halted,
    output logic [COUNT_W-1:0] cycle_count
);

    state_e state_q, state_d;
    logic [1:0] a_sync_q, b_sync_q;
    logic a_prev_q, b_prev_q;
    logic run_lvl, step_lvl, run_prev_q, step_prev_q;
    logic out_q, out_d, hp_q, hp_d;
    logic fetch_q, fetch_d, exec_q, exec_d;
    logic stop;
    logic [COUNT_W-1:0] cnt_q;

    logic fetch_ev, exec_ev, run_rise, step_rise;

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk_i  (clk_in),
        .rst_ni (rst_n),
        .btn_i  (run_btn),
        .level_o(run_lvl)
    );

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk_i  (clk_in),
        .rst_ni (rst_n),
        .btn_i  (step_btn),
        .level_o(step_lvl)
    );

    assign fetch_ev  = a_sync_q[1] & ~a_prev_q;
    assign exec_ev   = ~b_sync_q[1] & b_prev_q;
    assign run_rise  = run_lvl & ~run_prev_q;
    assign step_rise = step_lvl & ~step_prev_q;

    // out_q marks a fetch still owed its exec; hp_q a halt waiting on it
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        hp_d    = hp_q;
        fetch_d = 1'b0;
        exec_d  = 1'b0;
        stop    = 1'b0;
        unique case (state_q)
            HALT: begin
                out_d = 1'b0;
                hp_d  = 1'b0;
                if (run_rise)       state_d = RUN;
                else if (step_rise) state_d = STEP_FETCH;
            end
            RUN: begin
                stop = hp_q | run_rise | halt_req;
                if (exec_ev && out_q) begin
                    exec_d = 1'b1;
                    out_d  = 1'b0;
                end
                if (fetch_ev && !stop) begin
                    fetch_d = 1'b1;
                    out_d   = 1'b1;
                end
                hp_d = stop;
                if (stop && !out_d) begin
                    state_d = HALT;
                    hp_d    = 1'b0;
                end
            end
            STEP_FETCH: begin
                if (fetch_ev) begin
                    fetch_d = 1'b1;
                    state_d = STEP_EXEC;
                end
            end
            STEP_EXEC: begin
                if (exec_ev) begin
                    exec_d  = 1'b1;
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HALT;
            a_sync_q    <= 2'b00;
            b_sync_q    <= 2'b00;
            a_prev_q    <= 1'b0;
            b_prev_q    <= 1'b0;
            run_prev_q  <= 1'b0;
            step_prev_q <= 1'b0;
            out_q       <= 1'b0;
            hp_q        <= 1'b0;
            fetch_q     <= 1'b0;
            exec_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_sync_q    <= {a_sync_q[0], phase_a};
            b_sync_q    <= {b_sync_q[0], phase_b};
            a_prev_q    <= a_sync_q[1];
            b_prev_q    <= b_sync_q[1];
            run_prev_q  <= run_lvl;
            step_prev_q <= step_lvl;
            out_q       <= out_d;
            hp_q        <= hp_d;
            fetch_q     <= fetch_d;
            exec_q      <= exec_d;
            if (exec_d) cnt_q <= cnt_q + COUNT_W'(1);
        end
    end

    assign fetch_en    = fetch_q;
    assign exec_en     = exec_q;
    assign halted      = (state_q == HALT);
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenario table,
// hand-written corner sequences and random stimulus against a history model.
module tb_phase_sequencer;

    localparam int DB = 4;
    localparam int CW = 4;

    logic clk_in = 1'b0;
    logic rst_n = 1'b0;
    logic phase_a = 1'b0, phase_b = 1'b0;
    logic run_btn = 1'b0, step_btn = 1'b0, halt_req = 1'b0;
    logic fetch_en, exec_en, halted;
    logic [CW-1:0] cycle_count;

    phase_sequencer #(.DEBOUNCE_CYCLES(DB), .COUNT_W(CW)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .phase_a    (phase_a),
        .phase_b    (phase_b),
        .run_btn    (run_btn),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .fetch_en   (fetch_en),
        .exec_en    (exec_en),
        .halted     (halted),
        .cycle_count(cycle_count)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0, n_fail = 0;
    int fcnt = 0, ecnt = 0;

    // model: raw input histories per clock edge, index 0 = newest sample
    bit ha[4], hb[4];
    bit hr[DB+2], hs[DB+2];
    bit rq[2], sq[2];
    int mode;          // 0 halted, 1 running, 2 step awaiting fetch, 3 step awaiting exec
    bit owed, stopping;
    int mcnt;
    bit mfe, mee;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin ha[i] = 0; hb[i] = 0; end
        for (int i = 0; i < DB+2; i++) begin hr[i] = 0; hs[i] = 0; end
        rq[0] = 0; rq[1] = 0; sq[0] = 0; sq[1] = 0;
        mode = 0; owed = 0; stopping = 0; mcnt = 0; mfe = 0; mee = 0;
    endfunction

    function automatic bit settled(bit cur, bit h[DB+2]);
        // a new level is accepted once DB synchronized samples all differ
        for (int i = 2; i < DB+2; i++) if (h[i] == cur) return cur;
        return !cur;
    endfunction

    function automatic void model_step();
        bit f, e, rr, sr, nr, ns;
        if (!rst_n) begin model_reset(); return; end
        for (int i = 3; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
        ha[0] = phase_a; hb[0] = phase_b;
        for (int i = DB+1; i > 0; i--) begin hr[i] = hr[i-1]; hs[i] = hs[i-1]; end
        hr[0] = run_btn; hs[0] = step_btn;
        f  = ha[2] & !ha[3];
        e  = !hb[2] & hb[3];
        rr = rq[0] & !rq[1];
        sr = sq[0] & !sq[1];
        nr = settled(rq[0], hr);
        ns = settled(sq[0], hs);
        rq[1] = rq[0]; rq[0] = nr;
        sq[1] = sq[0]; sq[0] = ns;
        mfe = 0; mee = 0;
        case (mode)
            0: begin
                owed = 0; stopping = 0;
                if (rr) mode = 1;
                else if (sr) mode = 2;
            end
            1: begin
                if (rr || halt_req) stopping = 1;
                if (e && owed) begin mee = 1; owed = 0; end
                if (f && !stopping) begin mfe = 1; owed = 1; end
                if (stopping && !owed) begin mode = 0; stopping = 0; end
            end
            2: if (f) begin mfe = 1; mode = 3; end
            default: if (e) begin mee = 1; mode = 0; end
        endcase
        mcnt = (mcnt + int'(mee)) % (1 << CW);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        fcnt += int'(fetch_en);
        ecnt += int'(exec_en);
        chk("fetch_en", fetch_en, mfe);
        chk("exec_en", exec_en, mee);
        chk("halted", halted, mode == 0);
        chk("cycle_count", cycle_count, mcnt);
    endtask

    task automatic press(bit r, bit s, int len);
        run_btn = r; step_btn = s;
        repeat (len) tick();
        run_btn = 0; step_btn = 0;
        repeat (DB+4) tick();
    endtask

    task automatic run_periods(int n, int p);
        for (int i = 0; i < n; i++)
            for (int t = 0; t < p; t++) begin
                phase_a = (t < p/2);
                phase_b = (t < (3*p)/4);
                tick();
            end
        phase_a = 0; phase_b = 0;
    endtask

    typedef struct {
        bit use_run;
        int periods;
        int period;
        int exp_f;
        int exp_e;
        int exp_cnt;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int f0, e0, w, t, p, bl, sel;
        tbl[0] = '{1'b1, 10, 8,  10, 10, 10};
        tbl[1] = '{1'b0, 3,  8,  1,  1,  11};
        tbl[2] = '{1'b1, 5,  6,  5,  5,  0};
        tbl[3] = '{1'b0, 2,  12, 1,  1,  1};
        model_reset();

        repeat (2) tick();
        chk("rst_halted", halted, 1);
        chk("rst_fetch", fetch_en, 0);
        chk("rst_count", cycle_count, 0);
        rst_n = 1;

        press(1, 0, DB-1);
        chk("db_short_halted", halted, 1);
        press(1, 0, DB);
        chk("db_full_run", halted, 0);
        press(1, 0, DB);
        chk("db_halt_again", halted, 1);

        foreach (tbl[i]) begin
            f0 = fcnt; e0 = ecnt;
            press(tbl[i].use_run, !tbl[i].use_run, DB+1);
            chk("vec_active", halted, 0);
            run_periods(tbl[i].periods, tbl[i].period);
            repeat (4) tick();
            if (tbl[i].use_run) press(1, 0, DB+1);
            chk("vec_fetches", fcnt - f0, tbl[i].exp_f);
            chk("vec_execs", ecnt - e0, tbl[i].exp_e);
            chk("vec_count", cycle_count, tbl[i].exp_cnt);
            chk("vec_halted", halted, 1);
        end

        press(1, 0, DB+1);
        f0 = fcnt;
        phase_a = 1; phase_b = 1;
        w = 0;
        while (fcnt == f0 && w < 10) begin tick(); w++; end
        chk("halt_fetch_seen", fcnt - f0, 1);
        halt_req = 1; tick(); halt_req = 0;
        phase_a = 0; repeat (2) tick();
        e0 = ecnt; phase_b = 0;
        w = 0;
        while (ecnt == e0 && w < 10) begin tick(); w++; end
        chk("halt_exec_seen", ecnt - e0, 1);
        repeat (3) tick();
        chk("halt_after_exec", halted, 1);
        f0 = fcnt;
        run_periods(3, 8);
        chk("halt_no_fetch", fcnt - f0, 0);

        press(1, 0, DB+1);
        phase_a = 1; phase_b = 1;
        repeat (5) tick();
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("arst_fetch", fetch_en, 0);
        chk("arst_exec", exec_en, 0);
        chk("arst_halted", halted, 1);
        chk("arst_count", cycle_count, 0);
        repeat (2) tick();
        rst_n = 1;
        f0 = fcnt;
        repeat (6) tick();
        press(1, 0, DB+1);
        chk("arst_run", halted, 0);
        chk("arst_no_fetch", fcnt - f0, 0);
        phase_a = 0; phase_b = 0;
        repeat (4) tick();
        run_periods(2, 8);
        repeat (4) tick();
        chk("arst_fetch2", fcnt - f0, 2);
        chk("arst_count2", cycle_count, 2);
        press(1, 0, DB+1);

        t = 0; p = 8; bl = 0; sel = 0;
        for (int c = 0; c < 3000; c++) begin
            if (t >= p) begin t = 0; p = $urandom_range(4, 14); end
            phase_a = (t < p/2);
            phase_b = (t < (3*p)/4);
            t++;
            halt_req = ($urandom_range(0, 29) == 0);
            if (bl == 0 && $urandom_range(0, 79) == 0) begin
                bl = $urandom_range(1, 8);
                sel = $urandom_range(0, 3);
            end
            run_btn  = (bl > 0) && (sel != 1);
            step_btn = (bl > 0) && (sel == 1 || sel == 2);
            if (bl > 0) bl--;
            tick();
        end
        halt_req = 0; run_btn = 0; step_btn = 0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
